// File: rtl/traffic_pkg.sv
// Shared lamp encodings and controller state codes
// for the timed intersection controller.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
        SIDE_YELLOW = 3'd3,
        WALK        = 3'd4,
        ALL_RED     = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] main_lamp;
        logic [1:0] side_lamp;
        logic       walk_lamp;
    } lamps_t;

    function automatic lamps_t lamps_of(input state_t st);
        lamps_t l;
        l = '{main_lamp: LAMP_RED, side_lamp: LAMP_RED, walk_lamp: 1'b0};
        case (st)
            MAIN_GREEN:  l.main_lamp = LAMP_GREEN;
            MAIN_YELLOW: l.main_lamp = LAMP_YELLOW;
            SIDE_GREEN:  l.side_lamp = LAMP_GREEN;
            SIDE_YELLOW: l.side_lamp = LAMP_YELLOW;
            WALK:        l.walk_lamp = 1'b1;
            default:     l = l;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks,
// realigned to zero whenever restart is asserted.
module tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/timed_intersection.sv
// Main/side/pedestrian intersection controller with tick-timed dwells.
// Define ALL_RED_CLEAR_EN to insert a one-tick all-red after each yellow.
module timed_intersection
    import traffic_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int T_MAIN_MIN   = 3,
    parameter int T_YELLOW     = 2,
    parameter int T_SIDE_GREEN = 4,
    parameter int T_EXT        = 2,
    parameter int T_SIDE_MAX   = 8,
    parameter int T_WALK       = 3,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk_light,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] MAIN_MIN  = CNT_W'(T_MAIN_MIN);
    localparam logic [CNT_W-1:0] YEL_TKS   = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] SIDE_BASE = CNT_W'(T_SIDE_GREEN);
    localparam logic [CNT_W-1:0] WALK_TKS  = CNT_W'(T_WALK);
    localparam logic [CNT_W:0]   EXT_W     = (CNT_W+1)'(T_EXT);
    localparam logic [CNT_W:0]   SIDE_CAP  = (CNT_W+1)'(T_SIDE_MAX);

    logic [1:0] sens_sync;
    logic [1:0] walk_sync;
    logic       sensor_s;
    logic       walk_s;

    state_t state;
    state_t state_next;
    state_t yellow_dest;

    logic             tick;
    logic             restart;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_inc;
    logic [CNT_W-1:0] timer_at;
    logic [CNT_W-1:0] side_end;
    logic [CNT_W-1:0] side_end_next;
    logic [CNT_W:0]   ext_sum;
    logic             sens_req;
    logic             walk_req;
    lamps_t           lamps;

`ifdef ALL_RED_CLEAR_EN
    state_t clear_target;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sens_sync <= '0;
            walk_sync <= '0;
        end else begin
            sens_sync <= {sens_sync[0], sensor};
            walk_sync <= {walk_sync[0], walk};
        end
    end

    assign sensor_s = sens_sync[1];
    assign walk_s   = walk_sync[1];

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    assign timer_at  = tick ? timer_inc : timer;
    assign restart   = (state_next != state);

    // Extension end time; only a sensor sample on a tick can move it.
    always_comb begin
        side_end_next = side_end;
        ext_sum       = {1'b0, timer_inc} + EXT_W;
        if (ext_sum > SIDE_CAP) begin
            ext_sum = SIDE_CAP;
        end
        if (tick && sensor_s && (ext_sum > {1'b0, side_end})) begin
            side_end_next = ext_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_next  = state;
        yellow_dest = MAIN_GREEN;
        if (state == MAIN_YELLOW) begin
            yellow_dest = sens_req ? SIDE_GREEN : WALK;
        end else begin
            yellow_dest = walk_req ? WALK : MAIN_GREEN;
        end
        unique case (state)
            MAIN_GREEN: begin
                if ((sens_req || walk_req) && timer_at >= MAIN_MIN) begin
                    state_next = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW, SIDE_YELLOW: begin
                if (tick && timer_inc >= YEL_TKS) begin
`ifdef ALL_RED_CLEAR_EN
                    state_next = ALL_RED;
`else
                    state_next = yellow_dest;
`endif
                end
            end
            SIDE_GREEN: begin
                if (tick && timer_inc >= side_end_next) begin
                    state_next = SIDE_YELLOW;
                end
            end
            WALK: begin
                if (tick && timer_inc >= WALK_TKS) begin
                    state_next = MAIN_GREEN;
                end
            end
            ALL_RED: begin
`ifdef ALL_RED_CLEAR_EN
                if (tick) begin
                    state_next = clear_target;
                end
`else
                state_next = MAIN_GREEN;
`endif
            end
            default: state_next = MAIN_GREEN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= MAIN_GREEN;
            timer    <= '0;
            side_end <= SIDE_BASE;
        end else begin
            state <= state_next;
            if (restart) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer_inc;
            end
            if (state == SIDE_GREEN && !restart) begin
                side_end <= side_end_next;
            end else begin
                side_end <= SIDE_BASE;
            end
        end
    end

`ifdef ALL_RED_CLEAR_EN
    // Target is frozen at yellow exit so late requests cannot redirect it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_target <= MAIN_GREEN;
        end else if (state != ALL_RED) begin
            clear_target <= yellow_dest;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sens_req <= 1'b0;
            walk_req <= 1'b0;
        end else begin
            if (state_next == SIDE_GREEN && state != SIDE_GREEN) begin
                sens_req <= 1'b0;
            end else if (sensor_s && state != SIDE_GREEN) begin
                sens_req <= 1'b1;
            end
            if (state_next == WALK && state != WALK) begin
                walk_req <= 1'b0;
            end else if (walk_s && state != WALK) begin
                walk_req <= 1'b1;
            end
        end
    end

    assign lamps      = lamps_of(state);
    assign main_light = lamps.main_lamp;
    assign side_light = lamps.side_lamp;
    assign walk_light = lamps.walk_lamp;
    assign state_o    = state;

endmodule

// File: tb/tb_timed_intersection.sv
// Directed bench for timed_intersection at default parameters;
// expected dwells are hand-derived (ALL_RED_CLEAR_EN adds all-red checks).
module tb_timed_intersection;

`ifdef ALL_RED_CLEAR_EN
    localparam int AR = 4;
`else
    localparam int AR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sensor = 1'b0;
    logic       walk = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk_light;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    timed_intersection dut (
        .clk        (clk),
        .reset      (reset),
        .sensor     (sensor),
        .walk       (walk),
        .main_light (main_light),
        .side_light (side_light),
        .walk_light (walk_light),
        .state_o    (state_o)
    );

    initial begin
        #3;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic lamps(input string tag, input int m, input int s,
                         input int w);
        check({tag, "_main"}, 32'(main_light), m);
        check({tag, "_side"}, 32'(side_light), s);
        check({tag, "_walk"}, 32'(walk_light), w);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget,
                              input bit clr, output int n);
        n = 0;
        while (state_o !== st && n < budget) begin
            @(negedge clk);
            n++;
            if (clr) begin
                sensor = 1'b0;
                walk = 1'b0;
            end
        end
    endtask

    task automatic dwell(input logic [2:0] st, output int n);
        n = 0;
        while (state_o === st && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic after_yellow(input string tag);
`ifdef ALL_RED_CLEAR_EN
        int n;
        check({tag, "_ar_state"}, 32'(state_o), 5);
        lamps({tag, "_ar"}, 0, 0, 0);
        dwell(3'd5, n);
        check({tag, "_ar_len"}, n, AR);
`else
        check({tag, "_no_ar"}, 32'(state_o == 3'd5), 0);
`endif
    endtask

    task automatic restart_seq(input logic s, input logic w);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sensor = s;
        walk = w;
    endtask

    initial begin
        int n;
        int a;
        int bad;

        #2;
        check("rst_state", 32'(state_o), 0);
        lamps("rst", 2, 0, 0);
        check("rst_timer", 32'(dut.timer), 0);
        check("rst_sreq", 32'(dut.sens_req), 0);
        check("rst_wreq", 32'(dut.walk_req), 0);
        check("rst_presc", 32'(dut.u_tick.cnt), 0);

        #18;
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dut.tick && n < 20);
        check("first_tick", n, 4);

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (state_o !== 3'd0 || main_light !== 2'b10) bad++;
        end
        check("idle_hold", bad, 0);
        check("idle_sat", 32'(dut.timer >= 8'd3), 1);

        // sensor pulse: full side cycle
        restart_seq(1'b1, 1'b0);
        a = 0;
        do begin
            @(negedge clk);
            a++;
            sensor = 1'b0;
        end while (!dut.sens_req && a < 20);
        check("sens_latency", a, 3);
        wait_state(3'd1, 100, 1'b1, n);
        check("s_to_my", a + n, 12);
        lamps("my", 1, 0, 0);
        dwell(3'd1, n);
        check("s_my_len", n, 8);
        after_yellow("s_my");
        check("s_sg_state", 32'(state_o), 2);
        lamps("sg", 0, 2, 0);
        check("s_sg_sreq", 32'(dut.sens_req), 0);
        dwell(3'd2, n);
        check("s_sg_len", n, 16);
        check("s_sy_state", 32'(state_o), 3);
        lamps("sy", 0, 1, 0);
        dwell(3'd3, n);
        check("s_sy_len", n, 8);
        after_yellow("s_sy");
        check("s_back_mg", 32'(state_o), 0);

        // sensor held: side green capped
        restart_seq(1'b1, 1'b0);
        wait_state(3'd2, 200, 1'b0, n);
        check("x_to_sg", n, 20 + AR);
        dwell(3'd2, n);
        check("x_sg_len", n, 32);
        check("x_sy_state", 32'(state_o), 3);
        sensor = 1'b0;

        // walk only
        restart_seq(1'b0, 1'b1);
        wait_state(3'd1, 100, 1'b1, n);
        check("w_to_my", n, 12);
        check("w_wreq", 32'(dut.walk_req), 1);
        dwell(3'd1, n);
        check("w_my_len", n, 8);
        after_yellow("w_my");
        check("w_walk_state", 32'(state_o), 4);
        lamps("wk", 0, 0, 1);
        check("w_wreq_clr", 32'(dut.walk_req), 0);
        dwell(3'd4, n);
        check("w_walk_len", n, 12);
        check("w_back_mg", 32'(state_o), 0);

        // sensor and walk together
        restart_seq(1'b1, 1'b1);
        wait_state(3'd1, 100, 1'b1, n);
        check("b_to_my", n, 12);
        dwell(3'd1, n);
        check("b_my_len", n, 8);
        after_yellow("b_my");
        check("b_sg_state", 32'(state_o), 2);
        dwell(3'd2, n);
        check("b_sg_len", n, 16);
        dwell(3'd3, n);
        check("b_sy_len", n, 8);
        after_yellow("b_sy");
        check("b_walk_state", 32'(state_o), 4);
        check("b_reqs", 32'({dut.sens_req, dut.walk_req}), 0);
        dwell(3'd4, n);
        check("b_walk_len", n, 12);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (state_o !== 3'd0) bad++;
        end
        check("b_once", bad, 0);

        // async reset during side green
        restart_seq(1'b1, 1'b0);
        wait_state(3'd2, 200, 1'b1, n);
        check("r_to_sg", n, 20 + AR);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("r_state", 32'(state_o), 0);
        lamps("r", 2, 0, 0);
        check("r_timer", 32'(dut.timer), 0);
        check("r_presc", 32'(dut.u_tick.cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("r_hold_mg", 32'(state_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timed_intersection.md
TIMED_INTERSECTION -- requirements
Module: timed_intersection

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- CLK_DIV, 4: clk cycles per tick.
- T_MAIN_MIN, 3: minimum main-green ticks.
- T_YELLOW, 2: yellow ticks.
- T_SIDE_GREEN, 4: base side-green ticks.
- T_EXT, 2: extension ticks per sensor sample.
- T_SIDE_MAX, 8: side-green cap in ticks.
- T_WALK, 3: walk ticks.
- CNT_W, 8: timer width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset (0 = reset).
- sensor, in, 1: side-road vehicle present.
- walk, in, 1: pedestrian button.
- main_light, out, 2: main-road lamp.
- side_light, out, 2: side-road lamp.
- walk_light, out, 1: pedestrian lamp.
- state_o, out, 3: current state code, for debug.

Function
REQ-003 Lamp encoding SHALL be 00 red, 01 yellow, 10 green; 11 SHALL never be driven.
REQ-004 States SHALL be MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW, WALK, ALL_RED.
REQ-005 Outputs SHALL decode only from the state register, with no combinational path from sensor or walk.
REQ-006 Lamps per state: MAIN_GREEN 10/00/0; MAIN_YELLOW 01/00/0; SIDE_GREEN 00/10/0; SIDE_YELLOW 00/01/0; WALK 00/00/1; ALL_RED 00/00/0.
REQ-007 The prescaler SHALL restart on every state entry and pulse a one-cycle tick every CLK_DIV cycles, so a dwell of N ticks is exactly N*CLK_DIV cycles.
REQ-008 The tick timer SHALL clear on state entry and increment on each tick, saturating at 2^CNT_W-1.
REQ-009 sens_req SHALL set when sensor=1 in any state except SIDE_GREEN, and SHALL clear on entry to SIDE_GREEN.
REQ-010 walk_req SHALL set when walk=1 in any state except WALK, and SHALL clear on entry to WALK.
REQ-011 On the entry cycle of a state, the clear SHALL win over the set.
REQ-012 MAIN_GREEN -> MAIN_YELLOW when timer >= T_MAIN_MIN and (sens_req | walk_req); with no request, MAIN_GREEN SHALL be held indefinitely.
REQ-013 MAIN_YELLOW SHALL last T_YELLOW ticks, then go to SIDE_GREEN if sens_req, else to WALK.
REQ-014 SIDE_GREEN SHALL have a base length of T_SIDE_GREEN ticks.
REQ-015 In SIDE_GREEN, sensor=1 on a tick SHALL set the end time to max(end, timer+T_EXT), capped at T_SIDE_MAX; it then goes to SIDE_YELLOW.
REQ-016 SIDE_YELLOW SHALL last T_YELLOW ticks, then go to WALK if walk_req, else to MAIN_GREEN.
REQ-017 WALK SHALL last T_WALK ticks, then go to MAIN_GREEN.
REQ-018 sensor and walk SHALL each pass through a 2-flop synchronizer before use.
REQ-019 Request latency (input edge to flag set) SHALL be 3 cycles.

Reset
REQ-020 While reset=0, the state SHALL be MAIN_GREEN, the timer, prescaler and both request flags SHALL be 0, and the outputs SHALL be 10/00/0 with state_o=0.
REQ-021 Reset asserted mid-cycle (any state) SHALL force the REQ-020 values asynchronously, with no intermediate yellow.
REQ-022 After reset release, the first tick SHALL occur CLK_DIV cycles later.

Configuration
REQ-023 With ALL_RED_CLEAR_EN defined, every yellow exit SHALL pass through ALL_RED for 1 tick before the REQ-013/REQ-016 target is taken.
REQ-024 Without ALL_RED_CLEAR_EN, ALL_RED SHALL be unreachable and yellow SHALL exit directly.

Structure
REQ-025 Package traffic_pkg SHALL hold the lamp encoding constants and the state enum typedef with codes MAIN_GREEN=0 ... ALL_RED=5.
REQ-026 The prescaler SHALL be a sub-module tick_gen (clk, reset, restart, tick); the FSM, timer and request flags SHALL remain in the top level.

Verification (default parameters)
REQ-027 Reset low for 20 ns, then high, with no requests: main_light=10 for 200 cycles and no transition.
REQ-028 Pulse sensor at cycle 0: MAIN_YELLOW at 12 cycles from MAIN_GREEN entry, SIDE_GREEN 8 cycles later, 16-cycle side green, SIDE_YELLOW, then MAIN_GREEN.
REQ-029 Hold sensor=1 throughout SIDE_GREEN: the side green SHALL last exactly 32 cycles (T_SIDE_MAX cap).
REQ-030 Assert walk only: the sequence MAIN_YELLOW -> WALK with walk_light=1 for 12 cycles -> MAIN_GREEN; walk_req=0 after WALK entry.
REQ-031 Raise sensor and walk in the same cycle: SIDE_GREEN -> SIDE_YELLOW -> WALK -> MAIN_GREEN, with each request served exactly once.
REQ-032 Drive reset=0 during SIDE_GREEN: outputs 10/00/0 asynchronously; with ALL_RED_CLEAR_EN, 4 cycles of 00/00 SHALL follow each yellow.
